ex_stage_mc: RTL

//  Parametrised execute stage with an EX/MEM pipeline register for the pipelined core.

---
 rtl/ex_stage_mc.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_mc.sv
// Execute stage with EX/MEM pipeline register; forwarding muxes, 3-bit ALU and an
// iterative shift-add multiplier that is present only when EX_MULDIV_EN is defined.
module ex_stage_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IMM_WIDTH  = 8,
    parameter int REG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCE_i,
    input  logic [DATA_WIDTH-1:0] r1_data_r_i,
    input  logic [DATA_WIDTH-1:0] r2_data_r_i,
    input  logic [IMM_WIDTH-1:0]  imm8E_i,
    input  logic [REG_WIDTH-1:0]  rsE_i,
    input  logic [REG_WIDTH-1:0]  rdE_i,
    input  logic [2:0]            ALUopE_i,
    input  logic                  RegWriteE_i,
    input  logic                  BranchE_i,
    input  logic                  MemReadE_i,
    input  logic                  RegDstE_i,
    input  logic                  MemWriteE_i,
    input  logic                  MemToRegE_i,
    input  logic                  MovE_i,
    input  logic                  jumpE_i,
    input  logic [DATA_WIDTH-1:0] WBResultM_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [1:0]            alu_src1_i,
    input  logic [1:0]            alu_src2_i,
    input  logic                  flush_EX_MEM_i,
    input  logic                  stall_EX_MEM_i,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] PCM_o,
    output logic [DATA_WIDTH-1:0] WriteDataM_o,
    output logic [IMM_WIDTH-1:0]  imm8M_o,
    output logic [REG_WIDTH-1:0]  rsM_o,
    output logic [REG_WIDTH-1:0]  WriteRegM_o,
    output logic [DATA_WIDTH-1:0] alu_outM_o,
    output logic                  RegWriteM_o,
    output logic                  BranchM_o,
    output logic                  MemReadM_o,
    output logic                  MemWriteM_o,
    output logic                  MemToRegM_o,
    output logic                  MovM_o,
    output logic                  jumpM_o
);
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] write_data;
        logic [IMM_WIDTH-1:0]  imm;
        logic [REG_WIDTH-1:0]  rs;
        logic [REG_WIDTH-1:0]  write_reg;
        logic [DATA_WIDTH-1:0] alu_out;
        logic                  reg_write;
        logic                  branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  mov;
        logic                  jump;
    } exmem_t;

    logic [DATA_WIDTH-1:0] alu_in1, alu_in2, alu_result;
    exmem_t ex_fields, load_fields, exmem_reg, exmem_next;
    logic busy;

    always_comb begin
        case (alu_src1_i)
            2'd1:    alu_in1 = WBResultM_i;
            2'd2:    alu_in1 = ResultW_i;
            default: alu_in1 = r1_data_r_i;
        endcase
        case (alu_src2_i)
            2'd1:    alu_in2 = WBResultM_i;
            2'd2:    alu_in2 = ResultW_i;
            default: alu_in2 = r2_data_r_i;
        endcase
    end

    always_comb begin
        case (ALUopE_i)
            3'b000:  alu_result = alu_in1 + alu_in2;
            3'b001:  alu_result = alu_in1 - alu_in2;
            3'b010:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (alu_in1 < alu_in2)};
            3'b011:  alu_result = alu_in1 & alu_in2;
            3'b100:  alu_result = alu_in1 | alu_in2;
            3'b101:  alu_result = alu_in1 ^ alu_in2;
            OP_MUL:  alu_result = '0;
            default: alu_result = alu_in1 << alu_in2[SHW-1:0];
        endcase
    end

    always_comb begin
        ex_fields            = '0;
        ex_fields.pc         = PCE_i;
        ex_fields.write_data = alu_in1;
        ex_fields.imm        = imm8E_i;
        ex_fields.rs         = rsE_i;
        ex_fields.write_reg  = RegDstE_i ? rsE_i : rdE_i;
        ex_fields.alu_out    = alu_result;
        ex_fields.reg_write  = RegWriteE_i;
        ex_fields.branch     = BranchE_i;
        ex_fields.mem_read   = MemReadE_i;
        ex_fields.mem_write  = MemWriteE_i;
        ex_fields.mem_to_reg = MemToRegE_i;
        ex_fields.mov        = MovE_i;
        ex_fields.jump       = jumpE_i;
    end

`ifdef EX_MULDIV_EN
    localparam int CNT_W = SHW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] mcand_reg, mcand_next, mplier_reg, mplier_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    exmem_t                lat_reg, lat_next;

    // lat_reg.alu_out doubles as the product accumulator.
    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        lat_next    = lat_reg;
        busy        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ALUopE_i == OP_MUL && !flush_EX_MEM_i) begin
                    busy             = 1'b1;
                    state_next       = BUSY;
                    mcand_next       = alu_in1;
                    mplier_next      = alu_in2;
                    cnt_next         = '0;
                    lat_next         = ex_fields;
                    lat_next.alu_out = '0;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (mplier_reg[0])
                    lat_next.alu_out = lat_reg.alu_out + mcand_reg;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(DATA_WIDTH - 1))
                    state_next = DONE;
            end
            default: begin
                if (!stall_EX_MEM_i)
                    state_next = IDLE;
            end
        endcase
        if (flush_EX_MEM_i) begin
            state_next = IDLE;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            lat_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            lat_reg    <= lat_next;
        end
    end

    assign load_fields = (state_reg == DONE) ? lat_reg : ex_fields;
`else
    assign busy        = 1'b0;
    assign load_fields = ex_fields;
`endif

    always_comb begin
        exmem_next = exmem_reg;
        if (flush_EX_MEM_i || (busy && !stall_EX_MEM_i)) begin
            exmem_next           = '0;
            exmem_next.write_reg = '1;
        end else if (!stall_EX_MEM_i) begin
            exmem_next = load_fields;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            exmem_reg <= '0;
        else
            exmem_reg <= exmem_next;
    end

    assign busy_o       = busy;
    assign PCM_o        = exmem_reg.pc;
    assign WriteDataM_o = exmem_reg.write_data;
    assign imm8M_o      = exmem_reg.imm;
    assign rsM_o        = exmem_reg.rs;
    assign WriteRegM_o  = exmem_reg.write_reg;
    assign alu_outM_o   = exmem_reg.alu_out;
    assign RegWriteM_o  = exmem_reg.reg_write;
    assign BranchM_o    = exmem_reg.branch;
    assign MemReadM_o   = exmem_reg.mem_read;
    assign MemWriteM_o  = exmem_reg.mem_write;
    assign MemToRegM_o  = exmem_reg.mem_to_reg;
    assign MovM_o       = exmem_reg.mov;
    assign jumpM_o      = exmem_reg.jump;
endmodule
